alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 187 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU feeding an in-order result queue drained by the CDB.
// Every accepted op occupies one credit (count) from acceptance until the CDB takes it, so the queue cannot overflow.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

module alu_pipe #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = `ROB_SIZE_WIDTH,
    parameter int STAGES    = 1,
    parameter int OUT_DEPTH = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  opr1_in,
    input  logic [XLEN-1:0]  opr2_in,
    input  logic [TAG_W-1:0] rob_id_in,
    input  logic [3:0]       op_L1_in,
    input  logic             op_L2_in,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [XLEN-1:0]  value_out,
    output logic [TAG_W-1:0] rob_id_out
);
    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] qcnt_q, qcnt_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic             acc;
    logic             deq;
    logic             wr_en;
    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  sra_res;
    logic [XLEN-1:0]  alu_res;

    assign in_ready  = (count_q < CNT_W'(OUT_DEPTH));
    assign out_valid = (qcnt_q != '0);

    assign acc = in_valid & in_ready & rdy_in & ~flush_in;
    assign deq = out_valid & out_ack & rdy_in & ~flush_in;

    assign shamt   = opr2_in[SHW-1:0];
    assign sra_res = $signed(opr1_in) >>> shamt;

    always_comb begin
        alu_res = '0;
        case (op_L1_in)
            4'b0000: alu_res = op_L2_in ? (opr1_in - opr2_in) : (opr1_in + opr2_in);
            4'b0001: alu_res = opr1_in << shamt;
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(opr1_in) < $signed(opr2_in)};
            4'b0011: alu_res = {{(XLEN-1){1'b0}}, opr1_in < opr2_in};
            4'b0100: alu_res = opr1_in ^ opr2_in;
            4'b0101: alu_res = op_L2_in ? sra_res : (opr1_in >> shamt);
            4'b0110: alu_res = opr1_in | opr2_in;
            4'b0111: alu_res = opr1_in & opr2_in;
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, opr1_in == opr2_in};
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, opr1_in != opr2_in};
            4'b1101: alu_res = {{(XLEN-1){1'b0}}, $signed(opr1_in) >= $signed(opr2_in)};
            4'b1111: alu_res = {{(XLEN-1){1'b0}}, opr1_in >= opr2_in};
            default: alu_res = '0;
        endcase
    end

    // Stage 0 is the combinational result; the last stage writes the queue tail.
    logic             st_v   [STAGES];
    logic [XLEN-1:0]  st_val [STAGES];
    logic [TAG_W-1:0] st_tag [STAGES];

    assign st_v[0]   = acc;
    assign st_val[0] = alu_res;
    assign st_tag[0] = rob_id_in;

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        logic             v_q;
        logic [XLEN-1:0]  val_q;
        logic [TAG_W-1:0] tag_q;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                v_q   <= 1'b0;
                val_q <= '0;
                tag_q <= '0;
            end else if (flush_in) begin
                v_q <= 1'b0;
            end else if (rdy_in) begin
                v_q <= st_v[gi-1];
                if (st_v[gi-1]) begin
                    val_q <= st_val[gi-1];
                    tag_q <= st_tag[gi-1];
                end
            end
        end

        assign st_v[gi]   = v_q;
        assign st_val[gi] = val_q;
        assign st_tag[gi] = tag_q;
    end

    assign wr_en = st_v[STAGES-1] & rdy_in & ~flush_in;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [XLEN-1:0]  q_rd_val [OUT_DEPTH];
    logic [TAG_W-1:0] q_rd_tag [OUT_DEPTH];

    // Entries reset to zero so the head reads 0 out of reset.
    for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_qent
        logic [XLEN-1:0]  val_q;
        logic [TAG_W-1:0] tag_q;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                val_q <= '0;
                tag_q <= '0;
            end else if (wr_en && (tail_q == PTR_W'(gi))) begin
                val_q <= st_val[STAGES-1];
                tag_q <= st_tag[STAGES-1];
            end
        end

        assign q_rd_val[gi] = val_q;
        assign q_rd_tag[gi] = tag_q;
    end

    assign value_out  = q_rd_val[head_q];
    assign rob_id_out = q_rd_tag[head_q];

    always_comb begin
        count_d = count_q;
        qcnt_d  = qcnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_in) begin
            count_d = '0;
            qcnt_d  = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case ({acc, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            case ({wr_en, deq})
                2'b10:   qcnt_d = qcnt_q + 1'b1;
                2'b01:   qcnt_d = qcnt_q - 1'b1;
                default: qcnt_d = qcnt_q;
            endcase
            if (wr_en) tail_d = ptr_inc(tail_q);
            if (deq)   head_d = ptr_inc(head_q);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
            qcnt_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            qcnt_q  <= qcnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            assert (count_q <= CNT_W'(OUT_DEPTH));
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: opcode sweep on a single-stage instance, and a reference-model
// driven run of reset, backpressure, pointer wrap, flush and rdy_in stall on a two-stage instance.
`timescale 1ns/1ps

module tb_alu_pipe;
    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int B_DEPTH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic             a_rdy, a_flush, a_in_valid, a_in_ready, a_l2, a_out_valid, a_ack;
    logic [XLEN-1:0]  a_op1, a_op2, a_val;
    logic [TAG_W-1:0] a_tag, a_tag_o;
    logic [3:0]       a_l1;

    logic             b_rdy, b_flush, b_in_valid, b_in_ready, b_l2, b_out_valid, b_ack;
    logic [XLEN-1:0]  b_op1, b_op2, b_val;
    logic [TAG_W-1:0] b_tag, b_tag_o;
    logic [3:0]       b_l1;

    alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(1), .OUT_DEPTH(2)) u_a (
        .clk_in(clk), .rst_in(rst), .rdy_in(a_rdy), .flush_in(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .opr1_in(a_op1), .opr2_in(a_op2), .rob_id_in(a_tag),
        .op_L1_in(a_l1), .op_L2_in(a_l2),
        .out_valid(a_out_valid), .out_ack(a_ack),
        .value_out(a_val), .rob_id_out(a_tag_o)
    );

    alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(2), .OUT_DEPTH(B_DEPTH)) u_b (
        .clk_in(clk), .rst_in(rst), .rdy_in(b_rdy), .flush_in(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .opr1_in(b_op1), .opr2_in(b_op2), .rob_id_in(b_tag),
        .op_L1_in(b_l1), .op_L2_in(b_l2),
        .out_valid(b_out_valid), .out_ack(b_ack),
        .value_out(b_val), .rob_id_out(b_tag_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  l1;
        logic        l2;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input string n, input logic [3:0] l1, input logic l2,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        vec_t v;
        v.name = n; v.l1 = l1; v.l2 = l2; v.a = a; v.b = b; v.exp = e;
        vecs.push_back(v);
    endtask

    // Reference model of the two-stage instance: one pipe register plus an ordered queue.
    typedef struct packed {
        logic [31:0] v;
        logic [3:0]  t;
    } ent_t;

    ent_t        m_q[$];
    logic        m_pv;
    logic [31:0] m_pval;
    logic [3:0]  m_ptag;
    int          m_count;

    task automatic m_reset();
        m_q.delete();
        m_pv    = 1'b0;
        m_pval  = '0;
        m_ptag  = '0;
        m_count = 0;
    endtask

    task automatic b_check();
        chk("b_in_ready", {31'b0, b_in_ready}, {31'b0, m_count < B_DEPTH});
        chk("b_out_valid", {31'b0, b_out_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("b_value_out", b_val, m_q[0].v);
            chk("b_rob_id_out", {28'b0, b_tag_o}, {28'b0, m_q[0].t});
        end
    endtask

    task automatic b_step(output bit accepted);
        bit acc, deq;
        acc = b_in_valid && (m_count < B_DEPTH) && b_rdy && !b_flush;
        deq = (m_q.size() != 0) && b_ack && b_rdy && !b_flush;
        @(posedge clk);
        #1;
        if (b_flush) begin
            m_reset();
        end else if (b_rdy) begin
            if (deq) begin
                $display("B deq tag=%0d value=%h", m_q[0].t, m_q[0].v);
                void'(m_q.pop_front());
            end
            if (m_pv) m_q.push_back('{v: m_pval, t: m_ptag});
            m_pv = acc;
            if (acc) begin
                m_pval = b_op1 + b_op2;
                m_ptag = b_tag;
            end
            m_count += int'(acc) - int'(deq);
        end
        accepted = acc;
        b_check();
    endtask

    task automatic b_drive(input int k);
        b_in_valid = 1'b1;
        b_l1  = 4'b0000;
        b_l2  = 1'b0;
        b_tag = TAG_W'(k);
        b_op1 = 32'h1000_0000 + 32'(k) * 32'h111;
        b_op2 = 32'(k);
    endtask

    task automatic b_issue(input int k, input int bound);
        bit got;
        int n;
        b_drive(k);
        got = 1'b0;
        n = 0;
        while (!got && n < bound) begin
            b_step(got);
            n++;
        end
        chk("b_issue_accepted", {31'b0, got}, 32'd1);
        b_in_valid = 1'b0;
    endtask

    task automatic b_drain(input int bound);
        bit got;
        int n;
        b_in_valid = 1'b0;
        n = 0;
        while (m_count != 0 && n < bound) begin
            b_step(got);
            n++;
        end
        chk("b_drain_empty", 32'(m_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;

        rst = 1'b1;
        a_rdy = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_ack = 1'b0;
        a_op1 = '0; a_op2 = '0; a_tag = '0; a_l1 = '0; a_l2 = 1'b0;
        b_rdy = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_ack = 1'b0;
        b_op1 = '0; b_op2 = '0; b_tag = '0; b_l1 = '0; b_l2 = 1'b0;
        m_reset();

        // Reset values, then release mid-cycle.
        repeat (2) @(posedge clk);
        #3;
        chk("a_rst_out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("a_rst_in_ready", {31'b0, a_in_ready}, 32'd1);
        chk("a_rst_value", a_val, 32'd0);
        chk("a_rst_tag", {28'b0, a_tag_o}, 32'd0);
        chk("b_rst_out_valid", {31'b0, b_out_valid}, 32'd0);
        chk("b_rst_in_ready", {31'b0, b_in_ready}, 32'd1);
        chk("b_rst_value", b_val, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Opcode sweep on the single-stage instance.
        addv("ADD",        4'b0000, 1'b0, 32'd5,          32'd7,          32'd12);
        addv("ADD_wrap",   4'b0000, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0);
        addv("SUB",        4'b0000, 1'b1, 32'd3,          32'd5,          32'hFFFF_FFFE);
        addv("SLL",        4'b0001, 1'b0, 32'h8000_0000,  32'h0000_0021,  32'h0000_0000);
        addv("SLL_31",     4'b0001, 1'b0, 32'h0000_0001,  32'h0000_003F,  32'h8000_0000);
        addv("SLT",        4'b0010, 1'b0, 32'h8000_0000,  32'h0000_0021,  32'd1);
        addv("SLTU",       4'b0011, 1'b0, 32'h8000_0000,  32'h0000_0021,  32'd0);
        addv("XOR",        4'b0100, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0);
        addv("SRL",        4'b0101, 1'b0, 32'h8000_0000,  32'h0000_0021,  32'h4000_0000);
        addv("SRA",        4'b0101, 1'b1, 32'h8000_0000,  32'h0000_0021,  32'hC000_0000);
        addv("OR",         4'b0110, 1'b0, 32'hF0F0_F0F0,  32'h0F0F_0000,  32'hFFFF_F0F0);
        addv("AND",        4'b0111, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000);
        addv("SEQ_eq",     4'b1000, 1'b0, 32'd5,          32'd5,          32'd1);
        addv("SEQ_ne",     4'b1000, 1'b0, 32'd5,          32'd6,          32'd0);
        addv("SNE",        4'b1001, 1'b0, 32'd5,          32'd6,          32'd1);
        addv("SGE_neg",    4'b1101, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0);
        addv("SGE_eq",     4'b1101, 1'b0, 32'd7,          32'd7,          32'd1);
        addv("SGEU",       4'b1111, 1'b0, 32'h8000_0000,  32'h0000_0021,  32'd1);
        addv("SGEU_lo",    4'b1111, 1'b0, 32'h0000_0021,  32'h8000_0000,  32'd0);
        addv("UNDEF_1010", 4'b1010, 1'b0, 32'h8000_0000,  32'h0000_0021,  32'd0);
        addv("UNDEF_1011", 4'b1011, 1'b0, 32'd5,          32'd7,          32'd0);
        addv("UNDEF_1100", 4'b1100, 1'b0, 32'd5,          32'd7,          32'd0);
        addv("UNDEF_1110", 4'b1110, 1'b1, 32'd5,          32'd7,          32'd0);

        a_ack = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            a_in_valid = 1'b1;
            a_l1  = vecs[i].l1;
            a_l2  = vecs[i].l2;
            a_op1 = vecs[i].a;
            a_op2 = vecs[i].b;
            a_tag = TAG_W'(i + 3);
            chk("a_in_ready", {31'b0, a_in_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk({"a_valid_", vecs[i].name}, {31'b0, a_out_valid}, 32'd1);
            chk({"a_value_", vecs[i].name}, a_val, vecs[i].exp);
            chk({"a_tag_", vecs[i].name}, {28'b0, a_tag_o}, {28'b0, TAG_W'(i + 3)});
            $display("A op %s l1=%b l2=%b a=%h b=%h res=%h tag=%0d",
                     vecs[i].name, vecs[i].l1, vecs[i].l2, vecs[i].a, vecs[i].b, a_val, a_tag_o);
        end
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("a_drained", {31'b0, a_out_valid}, 32'd0);

        // Reset with an op in flight on the two-stage instance: it must never surface.
        b_drive(9);
        b_step(got);
        #2;
        rst = 1'b1;
        b_in_valid = 1'b0;
        #1;
        chk("b_async_rst_out_valid", {31'b0, b_out_valid}, 32'd0);
        chk("b_async_rst_in_ready", {31'b0, b_in_ready}, 32'd1);
        #2;
        rst = 1'b0;
        m_reset();
        chk("b_rst_value_after", b_val, 32'd0);
        repeat (4) b_step(got);

        // Backpressure: tag 4 stalls until the CDB starts acking.
        b_ack = 1'b0;
        for (int k = 1; k <= 3; k++) b_issue(k, 3);
        b_drive(4);
        repeat (3) b_step(got);
        chk("b_bp_in_ready_low", {31'b0, b_in_ready}, 32'd0);
        b_ack = 1'b1;
        b_issue(4, 6);
        b_drain(12);

        // Sustained accept + dequeue at count=OUT_DEPTH-1 wraps the pointers repeatedly.
        b_ack = 1'b1;
        for (int k = 0; k < 20; k++) b_issue((k + 1) % 16, 3);
        b_drain(12);

        // Flush with one queued, one in the pipe, and a competing accept and ack.
        b_ack = 1'b0;
        b_issue(1, 3);
        b_issue(2, 3);
        b_drive(3);
        b_ack = 1'b1;
        b_flush = 1'b1;
        b_step(got);
        b_flush = 1'b0;
        b_in_valid = 1'b0;
        b_ack = 1'b0;
        chk("b_flush_out_valid", {31'b0, b_out_valid}, 32'd0);
        chk("b_flush_in_ready", {31'b0, b_in_ready}, 32'd1);
        repeat (4) b_step(got);
        b_ack = 1'b1;
        b_issue(5, 3);
        b_drain(8);

        // rdy_in low for three cycles freezes the head while ack and valid are high.
        b_ack = 1'b0;
        b_issue(1, 3);
        b_issue(2, 3);
        b_issue(3, 3);
        b_ack = 1'b1;
        b_rdy = 1'b0;
        b_drive(4);
        repeat (3) b_step(got);
        b_rdy = 1'b1;
        b_issue(4, 6);
        b_issue(6, 3);
        b_drain(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
